// File: rtl/fp_mul_stage.sv
// fp_mul_stage: 3-stage pipelined IEEE-754 binary32 multiplier (round-nearest-even, flush-to-zero).
// Define FP_MUL_FLAGS_EN to add the Flags {invalid, overflow, underflow} output.
module fp_mul_stage #(
   parameter int DataWidth = 32,
   parameter int Latency   = 3
) (
   input  logic                 clk,
   input  logic                 aclr,
   input  logic                 DataInValid,
   output logic                 DataInRdy,
   input  logic [DataWidth-1:0] DataInA,
   input  logic [DataWidth-1:0] DataInB,
   output logic                 DataOutValid,
   input  logic                 DataOutRdy,
   output logic [DataWidth-1:0] DataOut
`ifdef FP_MUL_FLAGS_EN
   ,
   output logic [2:0]           Flags
`endif
);

   if (DataWidth != 32 || Latency != 3) begin : gUnsupported
      $error("fp_mul_stage supports only DataWidth=32 and Latency=3");
   end

   typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} opClassT;

   logic stall;
   logic advance;

   // Operand unpack and classification
   logic [1:0][DataWidth-1:0] op;
   logic [1:0]                opSign, opZero, opInf, opNan;
   logic [1:0][7:0]           opExp;
   logic [1:0][23:0]          opMan;

   assign op[0] = DataInA;
   assign op[1] = DataInB;

   for (genvar gi = 0; gi < 2; gi++) begin : gOperand
      assign opSign[gi] = op[gi][31];
      assign opExp[gi]  = op[gi][30:23];
      assign opZero[gi] = (opExp[gi] == 8'h00);
      assign opInf[gi]  = (opExp[gi] == 8'hFF) && (op[gi][22:0] == 23'd0);
      assign opNan[gi]  = (opExp[gi] == 8'hFF) && (op[gi][22:0] != 23'd0);
      assign opMan[gi]  = {~opZero[gi], op[gi][22:0]};
   end

   opClassT            s1ClsNext;
   logic signed [10:0] s1ExpNext;

   always_comb begin
      s1ClsNext = ClsNorm;
      if ((|opNan) || (opInf[0] && opZero[1]) || (opInf[1] && opZero[0]))
         s1ClsNext = ClsNan;
      else if (|opInf)
         s1ClsNext = ClsInf;
      else if (|opZero)
         s1ClsNext = ClsZero;
   end

   assign s1ExpNext = {3'b000, opExp[0]} + {3'b000, opExp[1]} - 11'd127;

   // Pipeline registers
   logic               s1ValidReg, s2ValidReg, s3ValidReg;
   logic               s1SignReg, s2SignReg;
   logic signed [10:0] s1ExpReg, s2ExpReg;
   logic [23:0]        s1ManAReg, s1ManBReg;
   logic [47:0]        s2ProdReg;
   opClassT            s1ClsReg, s2ClsReg;
   logic [DataWidth-1:0] s3DataReg;

   // Normalize, round, pack
   logic                 normShift, guardBit, roundBit, stickyBit, roundUp;
   logic [23:0]          manPre;
   logic [24:0]          manRnd;
   logic [22:0]          manFrac;
   logic signed [10:0]   expAdj;
   logic [DataWidth-1:0] s3DataNext;

   always_comb begin
      normShift = s2ProdReg[47];
      if (normShift) begin
         manPre    = s2ProdReg[47:24];
         guardBit  = s2ProdReg[23];
         roundBit  = s2ProdReg[22];
         stickyBit = |s2ProdReg[21:0];
      end else begin
         manPre    = s2ProdReg[46:23];
         guardBit  = s2ProdReg[22];
         roundBit  = s2ProdReg[21];
         stickyBit = |s2ProdReg[20:0];
      end
      roundUp = guardBit & (roundBit | stickyBit | manPre[0]);
      manRnd  = {1'b0, manPre} + {24'd0, roundUp};
      // A rounding carry leaves 1.000..0, so the fraction is all zeros
      manFrac = manRnd[24] ? manRnd[23:1] : manRnd[22:0];
      expAdj  = s2ExpReg + {10'd0, normShift} + {10'd0, manRnd[24]};

      case (s2ClsReg)
         ClsNan:  s3DataNext = 32'h7FC0_0000;
         ClsInf:  s3DataNext = {s2SignReg, 8'hFF, 23'd0};
         ClsZero: s3DataNext = {s2SignReg, 31'd0};
         default: begin
            if (expAdj >= 11'sd255)
               s3DataNext = {s2SignReg, 8'hFF, 23'd0};
            else if (expAdj <= 11'sd0)
               s3DataNext = {s2SignReg, 31'd0};
            else
               s3DataNext = {s2SignReg, expAdj[7:0], manFrac};
         end
      endcase
   end

   assign stall        = s3ValidReg & ~DataOutRdy;
   assign advance      = ~stall;
   assign DataInRdy    = advance;
   assign DataOutValid = s3ValidReg;
   assign DataOut      = s3DataReg;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         s1ValidReg <= 1'b0;
         s1SignReg  <= 1'b0;
         s1ExpReg   <= '0;
         s1ManAReg  <= '0;
         s1ManBReg  <= '0;
         s1ClsReg   <= ClsNorm;
         s2ValidReg <= 1'b0;
         s2SignReg  <= 1'b0;
         s2ExpReg   <= '0;
         s2ProdReg  <= '0;
         s2ClsReg   <= ClsNorm;
         s3ValidReg <= 1'b0;
         s3DataReg  <= '0;
      end else if (advance) begin
         s1ValidReg <= DataInValid;
         s1SignReg  <= opSign[0] ^ opSign[1];
         s1ExpReg   <= s1ExpNext;
         s1ManAReg  <= opMan[0];
         s1ManBReg  <= opMan[1];
         s1ClsReg   <= s1ClsNext;
         s2ValidReg <= s1ValidReg;
         s2SignReg  <= s1SignReg;
         s2ExpReg   <= s1ExpReg;
         s2ProdReg  <= 48'(s1ManAReg) * 48'(s1ManBReg);
         s2ClsReg   <= s1ClsReg;
         s3ValidReg <= s2ValidReg;
         s3DataReg  <= s3DataNext;
      end
   end

`ifdef FP_MUL_FLAGS_EN
   // Subnormal inputs are flushed, which counts as an underflow event
   logic       s1SubInReg, s2SubInReg;
   logic       resOvf, resUdf;
   logic [2:0] flagsReg;
   logic [1:0] opSub;

   for (genvar gi = 0; gi < 2; gi++) begin : gSubnormal
      assign opSub[gi] = opZero[gi] && (op[gi][22:0] != 23'd0);
   end

   assign resOvf = (s2ClsReg == ClsNorm) && (expAdj >= 11'sd255);
   assign resUdf = (s2ClsReg == ClsNorm) && (expAdj <= 11'sd0);

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         s1SubInReg <= 1'b0;
         s2SubInReg <= 1'b0;
         flagsReg   <= 3'b000;
      end else if (advance) begin
         s1SubInReg <= |opSub;
         s2SubInReg <= s1SubInReg;
         flagsReg   <= {s2ClsReg == ClsNan, resOvf, resUdf | s2SubInReg};
      end
   end

   assign Flags = flagsReg;
`endif

endmodule

// File: doc/fp_mul_stage.md
FP_MUL_STAGE -- requirements
Module: fp_mul_stage

Interface
REQ-001 SHALL have parameter DataWidth, default 32, operand/result width; only 32 (IEEE-754 binary32) is supported.
REQ-002 SHALL have parameter Latency, default 3, fixed pipeline depth in cycles; informational, no other value is supported.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port aclr  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port DataInValid  input  1  operand pair on DataInA/DataInB is valid.
REQ-006 SHALL have port DataInRdy  output  1  block accepts an operand pair this cycle.
REQ-007 SHALL have port DataInA  input  DataWidth  multiplicand, binary32.
REQ-008 SHALL have port DataInB  input  DataWidth  multiplier, binary32.
REQ-009 SHALL have port DataOutValid  output  1  product on DataOut is valid; drives the downstream accumulator's DataInValid.
REQ-010 SHALL have port DataOutRdy  input  1  downstream accepts the product; driven by the accumulator's DataInRdy.
REQ-011 SHALL have port DataOut  output  DataWidth  product A*B, binary32.

Function
REQ-012 SHALL transfer an input only when DataInValid and DataInRdy are both 1 at a rising clk edge.
REQ-013 SHALL transfer an output only when DataOutValid and DataOutRdy are both 1 at a rising clk edge.
REQ-014 SHALL implement 3 register stages, each with its own valid bit: S1 unpack/sign XOR/exponent sum/special-case classify; S2 24x24 mantissa product; S3 normalize, round, pack.
REQ-015 SHALL hold all stages when stall = DataOutValid & ~DataOutRdy, and advance all stages otherwise.
REQ-016 SHALL drive DataInRdy = ~stall, combinationally.
REQ-017 SHALL present a product accepted in cycle N on DataOut with DataOutValid=1 in cycle N+3 when there are no stalls; each stall cycle adds exactly one cycle.
REQ-018 SHALL sustain one result per cycle with no bubbles when DataOutRdy is held at 1.
REQ-019 SHALL hold DataOut stable while DataOutValid=1 and DataOutRdy=0.
REQ-020 SHALL advance a bubble (valid=0) like data, so an empty stage never blocks the stages upstream of it.
REQ-021 SHALL set sign = signA XOR signB for all non-NaN results.
REQ-022 SHALL treat any operand with exponent 0 (zero or subnormal) as signed zero (flush-to-zero).
REQ-023 SHALL normalize a 48-bit mantissa product in [2,4) by shifting right 1 and incrementing the exponent.
REQ-024 SHALL round to nearest, ties to even, using guard/round/sticky bits, and renormalize when a mantissa carry occurs.
REQ-025 SHALL return signed infinity when the biased result exponent is >= 255 after rounding.
REQ-026 SHALL return signed zero when the biased result exponent is <= 0 (underflow flush).
REQ-027 SHALL return canonical NaN 0x7FC00000 when either input is NaN, or for Inf*0.
REQ-028 SHALL return signed infinity for Inf*finite nonzero and for Inf*Inf.
REQ-029 SHALL return signed zero for zero*finite.

Reset
REQ-030 SHALL, while aclr=1 (asynchronous), clear all stage valid bits, so DataOutValid=0 and DataInRdy=1.
REQ-031 SHALL drive DataOut=0x00000000 during reset and clear all datapath registers to 0.
REQ-032 SHALL discard any in-flight operands on assertion of aclr mid-operation; no stale result appears after release.
REQ-033 SHALL be able to accept an input on the first rising edge after aclr deasserts.

Configuration
REQ-034 SHALL, when FP_MUL_FLAGS_EN is defined, add output port Flags  output  3  {invalid, overflow, underflow}, pipelined alongside the result so it is valid with DataOutValid and held during stalls; invalid marks a REQ-027 case, overflow a REQ-025 case, underflow a REQ-026 case or a flushed subnormal input; reset value 3'b000.
REQ-035 SHALL, when FP_MUL_FLAGS_EN is not defined, have no Flags port and no flag logic, with all other behaviour identical.

Verification
REQ-036 SHALL cover: reset release, A=0x41700000 (15), B=0x40800000 (4), DataOutRdy=1 -> DataOut=0x42700000 (60) exactly 3 cycles after acceptance.
REQ-037 SHALL cover: back-to-back inputs 0x3FC00000*0x3FC00000, then 0xBF800000*0x40000000 -> outputs 0x40100000 then 0xC0000000 on consecutive cycles.
REQ-038 SHALL cover: 0x7F800000*0x00000000 -> 0x7FC00000 (Flags=3'b100 when FP_MUL_FLAGS_EN is defined); 0x7F000000*0x7F000000 -> 0x7F800000 (Flags=3'b010).
REQ-039 SHALL cover: 0x3F800001*0x3F800001 -> 0x3F800002 (rounding); 0x00800000*0x00800000 -> 0x00000000 (Flags=3'b001).
REQ-040 SHALL cover: three valid inputs, DataOutRdy=0 for 4 cycles -> DataInRdy=0 while stalled, DataOut held, all three results later delivered in order with none lost or duplicated.
REQ-041 SHALL cover: aclr pulsed with 2 products in flight -> DataOutValid=0 immediately, and neither product is ever output.
